// File: rtl/helios_host_pkg.sv
// -----------------------------------------------------------------------------
// helios_host_pkg
// Shared definitions for the host-side decoder session logic.
//   - session_state_t       : states of the session sequencer
//   - DEFAULT_RESULT_BYTES  : length of one decoder result frame
//   - START_DECODING_MSG    : control byte that opens a decoding session
//   - MEASUREMENT_DATA_HEADER : control byte that precedes each syndrome batch
// No ports; import with helios_host_pkg::*.
// -----------------------------------------------------------------------------
package helios_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_START,
      SEND_HDR,
      SEND_DATA,
      WAIT_RESULT,
      RECV_RESULT,
      PRESENT
   } session_state_t;

   // A result frame carries iterations, cycles[15:8] and cycles[7:0].
   localparam int DEFAULT_RESULT_BYTES = 3;

   // Message codes understood by the decoder's byte-stream front end.
   localparam logic [7:0] START_DECODING_MSG      = 8'h01;
   localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

endpackage

// File: rtl/session_timeout_counter.sv
// -----------------------------------------------------------------------------
// session_timeout_counter
// Counts cycles while enabled and pulses 'terminal' during the cycle in which
// the TIMEOUT_CYCLES-th enabled cycle is being counted.
//   clk      : clock
//   reset    : asynchronous active-high reset
//   clear    : synchronous clear, wins over enable
//   enable   : count this cycle
//   terminal : high while enabled on the last allowed cycle
// -----------------------------------------------------------------------------
module session_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Cycle counter: cleared when a wait window opens, advances while the
   // window is active. The owner leaves the window on terminal, so the
   // counter never needs to saturate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // The pulse marks the final permitted cycle, so the owner can act on the
   // same edge that would otherwise start cycle TIMEOUT_CYCLES+1.
   assign terminal = enable && (count == LAST);

endmodule

// File: rtl/decoder_session_controller.sv
// -----------------------------------------------------------------------------
// decoder_session_controller
// Host-side sequencer for the decoder byte-stream interface. Sends the start
// message once per session, then for every batch sends the measurement header
// and streams BYTES_PER_BATCH syndrome bytes, collects the result frame and
// presents it as a parsed record.
//   clk, reset                           : clock, async active-high reset
//   enable                               : keep running sessions/batches
//   syn_data/syn_valid/syn_ready         : syndrome byte source
//   dec_in_data/dec_in_valid/dec_in_ready: toward decoder input FIFO
//   dec_out_data/dec_out_valid/dec_out_ready : from decoder output FIFO
//   res_iterations/res_cycles/res_valid/res_ready : parsed result record
//   busy        : not idle
//   timeout_err : sticky, set when a result frame does not arrive in time
//   batch_count : completed batches since reset (wraps)
// -----------------------------------------------------------------------------
module decoder_session_controller
   import helios_host_pkg::*;
#(
   parameter int BYTES_PER_BATCH = 3,
   parameter int RESULT_BYTES    = DEFAULT_RESULT_BYTES,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  syn_data,
   input  logic        syn_valid,
   output logic        syn_ready,
   output logic [7:0]  dec_in_data,
   output logic        dec_in_valid,
   input  logic        dec_in_ready,
   input  logic [7:0]  dec_out_data,
   input  logic        dec_out_valid,
   output logic        dec_out_ready,
   output logic [7:0]  res_iterations,
   output logic [15:0] res_cycles,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
   output logic        timeout_err,
   output logic [31:0] batch_count
);

   localparam int BW = $clog2(BYTES_PER_BATCH + 1);
   localparam int FW = $clog2(RESULT_BYTES + 1);
   localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES_PER_BATCH - 1);
   localparam logic [FW-1:0] LAST_FRAME = FW'(RESULT_BYTES - 1);

   session_state_t state;
   session_state_t next_state;
   logic [BW-1:0]  byte_count;
   logic [FW-1:0]  frame_count;
   logic           data_hs;
   logic           last_data_hs;
   logic           timer_run;
   logic           timed_out;

   assign data_hs      = (state == SEND_DATA) && syn_valid && dec_in_ready;
   assign last_data_hs = data_hs && (byte_count == LAST_BYTE);
   assign timer_run    = (state == WAIT_RESULT) || (state == RECV_RESULT);
   assign busy         = (state != IDLE);

   // The timeout window opens on the edge that enters WAIT_RESULT and spans
   // both result-collection states.
   session_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear    (last_data_hs),
      .enable   (timer_run),
      .terminal (timed_out)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs. Control bytes depend only on the
   // registered state; SEND_DATA is a straight combinational pass-through
   // between the syndrome source and the decoder input. A timeout overrides
   // any byte accepted in the same cycle, so that byte is simply dropped.
   always_comb begin
      next_state    = state;
      dec_in_data   = 8'h00;
      dec_in_valid  = 1'b0;
      syn_ready     = 1'b0;
      dec_out_ready = 1'b0;
      res_valid     = 1'b0;
      case (state)
         IDLE: begin
            if (enable) next_state = SEND_START;
         end
         SEND_START: begin
            dec_in_data  = START_DECODING_MSG;
            dec_in_valid = 1'b1;
            if (dec_in_ready) next_state = SEND_HDR;
         end
         SEND_HDR: begin
            dec_in_data  = MEASUREMENT_DATA_HEADER;
            dec_in_valid = 1'b1;
            if (dec_in_ready) next_state = SEND_DATA;
         end
         SEND_DATA: begin
            dec_in_data  = syn_data;
            dec_in_valid = syn_valid;
            syn_ready    = dec_in_ready;
            if (last_data_hs) next_state = WAIT_RESULT;
         end
         WAIT_RESULT: begin
            dec_out_ready = 1'b1;
            if (dec_out_valid) next_state = (LAST_FRAME == '0) ? PRESENT : RECV_RESULT;
         end
         RECV_RESULT: begin
            dec_out_ready = 1'b1;
            if (dec_out_valid && (frame_count == LAST_FRAME)) next_state = PRESENT;
         end
         PRESENT: begin
            res_valid = 1'b1;
            if (res_ready) next_state = enable ? SEND_HDR : IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (timed_out) next_state = IDLE;
   end

   // Datapath: batch byte counter, result frame parser, batch counter and the
   // sticky timeout flag. The result fields only change while collecting a
   // frame, so they hold steady for the whole PRESENT window. Bytes beyond
   // index 2 of a longer frame are counted but not stored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_count     <= '0;
         frame_count    <= '0;
         res_iterations <= 8'h00;
         res_cycles     <= 16'h0000;
         batch_count    <= 32'h0;
         timeout_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) timeout_err <= 1'b0;
            end
            SEND_HDR: begin
               if (dec_in_ready) byte_count <= '0;
            end
            SEND_DATA: begin
               if (data_hs) byte_count <= byte_count + BW'(1);
            end
            WAIT_RESULT: begin
               if (dec_out_valid && !timed_out) begin
                  res_iterations <= dec_out_data;
                  frame_count    <= FW'(1);
               end
            end
            RECV_RESULT: begin
               if (dec_out_valid && !timed_out) begin
                  if (frame_count == FW'(1)) res_cycles[15:8] <= dec_out_data;
                  if (frame_count == FW'(2)) res_cycles[7:0]  <= dec_out_data;
                  frame_count <= frame_count + FW'(1);
               end
            end
            PRESENT: begin
               if (res_ready) batch_count <= batch_count + 32'd1;
            end
            default: ;
         endcase
         if (timed_out) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_decoder_session_controller.sv
// -----------------------------------------------------------------------------
// tb_decoder_session_controller
// Self-checking bench for decoder_session_controller. A queue-based model
// holds the byte stream the decoder input must see, the syndrome bytes still
// to be offered, the decoder's reply bytes and the records the host must get.
// -----------------------------------------------------------------------------
module tb_decoder_session_controller;
   import helios_host_pkg::*;

   localparam int BPB = 3;
   localparam int TMO = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [7:0]  syn_data;
   logic        syn_valid;
   logic        syn_ready;
   logic [7:0]  dec_in_data;
   logic        dec_in_valid;
   logic        dec_in_ready;
   logic [7:0]  dec_out_data;
   logic        dec_out_valid;
   logic        dec_out_ready;
   logic [7:0]  res_iterations;
   logic [15:0] res_cycles;
   logic        res_valid;
   logic        res_ready;
   logic        busy;
   logic        timeout_err;
   logic [31:0] batch_count;

   always #5 clk = ~clk;

   decoder_session_controller #(
      .BYTES_PER_BATCH (BPB),
      .RESULT_BYTES    (3),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .syn_data       (syn_data),
      .syn_valid      (syn_valid),
      .syn_ready      (syn_ready),
      .dec_in_data    (dec_in_data),
      .dec_in_valid   (dec_in_valid),
      .dec_in_ready   (dec_in_ready),
      .dec_out_data   (dec_out_data),
      .dec_out_valid  (dec_out_valid),
      .dec_out_ready  (dec_out_ready),
      .res_iterations (res_iterations),
      .res_cycles     (res_cycles),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .busy           (busy),
      .timeout_err    (timeout_err),
      .batch_count    (batch_count)
   );

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  expStream[$];
   bit          expKind[$];
   logic [7:0]  synQ[$];
   logic [7:0]  respQ[$];
   logic [23:0] recQ[$];
   logic [31:0] batchExp = 32'd0;
   bit          bpMode = 1'b0;
   int          resHold = 0;
   bit          synHs, decOutHs, resHs, decInHs;
   int          dataBatchesDone = 0;
   int          dataBytesSeen = 0;
   int          resBytesSeen = 0;
   int          negedgeCount = 0;
   bit          timeoutMode = 1'b0;
   bit          timeoutArmed = 1'b0;
   int          waitCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Per-cycle observation at the falling edge: compares DUT behaviour with
   // the model and records which handshakes complete on the next rising edge.
   task automatic monitorCycle();
      bit inData;
      bit wasData;
      negedgeCount++;
      synHs    = syn_valid && syn_ready;
      decInHs  = dec_in_valid && dec_in_ready;
      decOutHs = dec_out_valid && dec_out_ready;
      resHs    = res_valid && res_ready;

      checkOutput("batch_count", batch_count, batchExp);

      if (timeoutArmed) begin
         waitCount++;
         if (waitCount <= TMO) begin
            checkOutput("tmo_err_early", 32'(timeout_err), 32'd0);
            checkOutput("tmo_busy", 32'(busy), 32'd1);
         end else begin
            checkOutput("tmo_err_set", 32'(timeout_err), 32'd1);
            checkOutput("tmo_back_idle", 32'(busy), 32'd0);
            timeoutArmed = 1'b0;
         end
      end

      inData = (expKind.size() > 0) && expKind[0];
      if (!inData) begin
         checkOutput("syn_ready_outside_data", 32'(syn_ready), 32'd0);
      end else begin
         checkOutput("syn_ready_passthru", 32'(syn_ready), 32'(dec_in_ready));
         checkOutput("dec_in_valid_passthru", 32'(dec_in_valid), 32'(syn_valid));
         if (syn_valid) checkOutput("dec_in_data_passthru", 32'(dec_in_data), 32'(syn_data));
      end

      if (decInHs) begin
         if (expStream.size() == 0) begin
            checkOutput("dec_in_extra_byte", 32'(decInHs), 32'd0);
         end else begin
            wasData = expKind[0];
            checkOutput("dec_in_byte", 32'(dec_in_data), 32'(expStream.pop_front()));
            void'(expKind.pop_front());
            if (wasData) begin
               dataBytesSeen++;
               if ((expKind.size() == 0) || !expKind[0]) begin
                  dataBatchesDone++;
                  if (timeoutMode) begin
                     timeoutArmed = 1'b1;
                     waitCount    = 0;
                  end
               end
            end
         end
      end

      if (decOutHs) resBytesSeen++;

      if (res_valid) begin
         if (recQ.size() == 0) begin
            checkOutput("res_valid_unexpected", 32'(res_valid), 32'd0);
         end else begin
            checkOutput("res_record", {8'h00, res_iterations, res_cycles}, {8'h00, recQ[0]});
            if (resHs) begin
               void'(recQ.pop_front());
               batchExp = batchExp + 32'd1;
            end
         end
      end
   endtask

   // Source, decoder-output and host-sink models update just after the edge.
   task automatic driveInputs();
      if (synHs) begin
         void'(synQ.pop_front());
         syn_valid = 1'b0;
      end
      if (!syn_valid) begin
         if ((synQ.size() > 0) && (!bpMode || ($urandom_range(0, 3) != 0))) begin
            syn_valid = 1'b1;
            syn_data  = synQ[0];
         end else begin
            syn_data = 8'($urandom);
         end
      end
      if (decOutHs) void'(respQ.pop_front());
      if (respQ.size() > 0) begin
         dec_out_valid = 1'b1;
         dec_out_data  = respQ[0];
      end else begin
         dec_out_valid = 1'b0;
         dec_out_data  = 8'($urandom);
      end
      dec_in_ready = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (resHold > 0) begin
         res_ready = 1'b0;
         if (res_valid) resHold--;
      end else begin
         res_ready = bpMode ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      monitorCycle();
      @(posedge clk);
      #1;
      driveInputs();
   endtask

   task automatic loadStart();
      expStream.push_back(START_DECODING_MSG);
      expKind.push_back(1'b0);
   endtask

   // One batch: header, the data bytes in order, and the decoder reply whose
   // record is iterations plus a 16-bit cycle count built high byte first.
   task automatic loadBatch(input logic [23:0] dataBytes, input logic [23:0] frame);
      logic [7:0]  b;
      logic [15:0] cyc;
      expStream.push_back(MEASUREMENT_DATA_HEADER);
      expKind.push_back(1'b0);
      for (int i = 0; i < BPB; i++) begin
         b = dataBytes[23 - 8*i -: 8];
         synQ.push_back(b);
         expStream.push_back(b);
         expKind.push_back(1'b1);
      end
      respQ.push_back(frame[23:16]);
      respQ.push_back(frame[15:8]);
      respQ.push_back(frame[7:0]);
      cyc = 16'(frame[15:8]) * 16'd256 + 16'(frame[7:0]);
      recQ.push_back({frame[23:16], cyc});
   endtask

   task automatic loadRandomSession(input int nBatches);
      loadStart();
      for (int i = 0; i < nBatches; i++) loadBatch(24'($urandom), 24'($urandom));
   endtask

   task automatic runSession(input int nBatches, input bit dropOnRecv, input bit checkLatency);
      int startBatches;
      int startRes;
      int startData;
      int enNeg;
      int firstDataNeg;
      int budget;
      startBatches = dataBatchesDone;
      startRes     = resBytesSeen;
      startData    = dataBytesSeen;
      firstDataNeg = -1;
      budget       = 0;
      enable       = 1'b1;
      enNeg        = negedgeCount + 1;
      while (budget < 3000) begin
         applyStimulus();
         budget++;
         if ((firstDataNeg < 0) && (dataBytesSeen > startData)) firstDataNeg = negedgeCount;
         if (enable) begin
            if (!dropOnRecv && (dataBatchesDone - startBatches >= nBatches)) enable = 1'b0;
            if (dropOnRecv && (resBytesSeen - startRes >= (nBatches - 1) * 3 + 1)) enable = 1'b0;
         end
         if (!enable && (expStream.size() == 0) && (recQ.size() == 0) && !busy) break;
      end
      checkOutput("session_pending_items", 32'(expStream.size() + recQ.size()), 32'd0);
      checkOutput("session_busy_after", 32'(busy), 32'd0);
      checkOutput("session_syn_left", 32'(synQ.size()), 32'd0);
      checkOutput("session_timeout_err", 32'(timeout_err), 32'd0);
      if (checkLatency) checkOutput("first_data_latency", 32'(firstDataNeg - enNeg), 32'd3);
   endtask

   // The decoder replies with only two of the three frame bytes.
   task automatic runTimeoutSession();
      int startBatches;
      int budget;
      loadStart();
      expStream.push_back(MEASUREMENT_DATA_HEADER);
      expKind.push_back(1'b0);
      for (int i = 0; i < BPB; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         synQ.push_back(b);
         expStream.push_back(b);
         expKind.push_back(1'b1);
      end
      respQ.push_back(8'h07);
      respQ.push_back(8'h09);
      startBatches = dataBatchesDone;
      timeoutMode  = 1'b1;
      timeoutArmed = 1'b0;
      waitCount    = 0;
      budget       = 0;
      enable       = 1'b1;
      while (budget < 500) begin
         applyStimulus();
         budget++;
         if (enable && (dataBatchesDone > startBatches)) enable = 1'b0;
         if (!timeoutArmed && (waitCount > TMO)) break;
      end
      timeoutMode = 1'b0;
      checkOutput("tmo_window_seen", 32'(waitCount), 32'(TMO + 1));
      repeat (3) applyStimulus();
      checkOutput("tmo_err_sticky", 32'(timeout_err), 32'd1);
      checkOutput("tmo_resp_consumed", 32'(respQ.size()), 32'd0);
      checkOutput("tmo_stays_idle", 32'(busy), 32'd0);
   endtask

   task automatic runResetTest();
      int budget;
      int startData;
      loadRandomSession(1);
      startData = dataBytesSeen;
      budget    = 0;
      enable    = 1'b1;
      while ((dataBytesSeen == startData) && (budget < 100)) begin
         applyStimulus();
         budget++;
      end
      checkOutput("rst_reached_data", 32'(dataBytesSeen - startData), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_dec_in_valid", 32'(dec_in_valid), 32'd0);
      checkOutput("rst_dec_in_data", 32'(dec_in_data), 32'd0);
      checkOutput("rst_syn_ready", 32'(syn_ready), 32'd0);
      checkOutput("rst_dec_out_ready", 32'(dec_out_ready), 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      checkOutput("rst_batch_count", batch_count, 32'd0);
      checkOutput("rst_res_fields", {8'h00, res_iterations, res_cycles}, 32'd0);
      expStream.delete();
      expKind.delete();
      synQ.delete();
      respQ.delete();
      recQ.delete();
      batchExp      = 32'd0;
      enable        = 1'b0;
      syn_valid     = 1'b0;
      dec_out_valid = 1'b0;
      repeat (3) applyStimulus();
      reset = 1'b0;
      applyStimulus();
      loadRandomSession(1);
      runSession(1, 1'b0, 1'b1);
   endtask

   initial begin
      int n;
      reset         = 1'b1;
      enable        = 1'b0;
      syn_data      = 8'h00;
      syn_valid     = 1'b0;
      dec_in_ready  = 1'b0;
      dec_out_data  = 8'h00;
      dec_out_valid = 1'b0;
      res_ready     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("init_dec_in_valid", 32'(dec_in_valid), 32'd0);
      checkOutput("init_dec_in_data", 32'(dec_in_data), 32'd0);
      checkOutput("init_syn_ready", 32'(syn_ready), 32'd0);
      checkOutput("init_dec_out_ready", 32'(dec_out_ready), 32'd0);
      checkOutput("init_res_valid", 32'(res_valid), 32'd0);
      checkOutput("init_busy", 32'(busy), 32'd0);
      checkOutput("init_timeout_err", 32'(timeout_err), 32'd0);
      checkOutput("init_batch_count", batch_count, 32'd0);
      checkOutput("init_res_fields", {8'h00, res_iterations, res_cycles}, 32'd0);
      reset = 1'b0;
      applyStimulus();

      $display("[TB] directed batch 12 34 56, reply 05 01 2C");
      loadStart();
      loadBatch(24'h123456, 24'h05012C);
      resHold = 4;
      runSession(1, 1'b0, 1'b1);
      checkOutput("directed_batch_count", batch_count, 32'd1);
      checkOutput("directed_iterations", 32'(res_iterations), 32'd5);
      checkOutput("directed_cycles", 32'(res_cycles), 32'd300);

      $display("[TB] four batches with backpressure");
      bpMode = 1'b1;
      loadRandomSession(4);
      runSession(4, 1'b0, 1'b0);
      bpMode = 1'b0;
      checkOutput("four_batch_count", batch_count, 32'd5);

      $display("[TB] result timeout");
      runTimeoutSession();
      checkOutput("tmo_batch_unchanged", batch_count, 32'd5);

      $display("[TB] enable dropped while receiving");
      loadRandomSession(2);
      runSession(2, 1'b1, 1'b0);
      checkOutput("drop_recv_batch_count", batch_count, 32'd7);

      $display("[TB] reset during data phase");
      runResetTest();
      checkOutput("post_reset_batch_count", batch_count, 32'd1);

      $display("[TB] random sessions");
      for (int s = 0; s < 4; s++) begin
         bpMode = 1'($urandom_range(0, 1));
         n = 1 + int'($urandom_range(0, 2));
         loadRandomSession(n);
         runSession(n, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
